// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU engine that stalls the PC and writes HiLo once per op
// Ports:
//   Clk, Rst        clock and synchronous active-high reset
//   Start, Op, A, B request; Op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled only in IDLE
//   Stall           combinational hold for PC and register-file writes
//   Busy            registered; high while the op is in CALC or FIXUP
//   Done, HiLoEn    one-cycle pulse in WRITE
//   HiLoWrite       {Hi,Lo} result, held until the next op's FIXUP
//   DivByZero       high in WRITE when a divide had B==0
module hilo_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [1:0]         Op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Stall,
    output logic               Busy,
    output logic               Done,
    output logic               HiLoEn,
    output logic [2*WIDTH-1:0] HiLoWrite,
    output logic               DivByZero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, WRITE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic is_div, sign_q, sign_r, dbz, div_ok;
    logic [WIDTH-1:0] a_raw, mag_a, mag_b, hi, lo, hi_n, lo_n;
    logic [WIDTH+1:0] add_x, add_y, add_s;
    logic [2*WIDTH-1:0] result;
    assign mag_a = (!Op[0] && A[WIDTH-1]) ? -A : A;
    // One W+2 adder serves both ops: add for shift-add multiply,
    // subtract (x + ~b + 1) for the restoring-divide trial.
    always_comb begin
        add_x = is_div ? {1'b0, hi, lo[WIDTH-1]} : {2'b00, hi};
        add_y = is_div ? ~{2'b00, mag_b} : (lo[0] ? {2'b00, mag_b} : '0);
        add_s = add_x + add_y + {{(WIDTH+1){1'b0}}, is_div};
        div_ok = ~add_s[WIDTH+1];
        hi_n = is_div ? (div_ok ? add_s[WIDTH-1:0] : {hi[WIDTH-2:0], lo[WIDTH-1]}) : add_s[WIDTH:1];
        lo_n = is_div ? {lo[WIDTH-2:0], div_ok} : {add_s[0], lo[WIDTH-1:1]};
        result = dbz ? {a_raw, {WIDTH{1'b1}}} :
                 is_div ? {sign_r ? -hi : hi, sign_q ? -lo : lo} :
                 sign_q ? -{hi, lo} : {hi, lo};
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = Start ? CALC : IDLE;
            CALC:    state_n = (cnt == CW'(WIDTH - 1)) ? FIXUP : CALC;
            FIXUP:   state_n = WRITE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            Busy  <= 1'b0;
        end else begin
            state <= state_n;
            Busy  <= (state_n == CALC) || (state_n == FIXUP);
        end
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt       <= '0;
            is_div    <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dbz       <= 1'b0;
            a_raw     <= '0;
            mag_b     <= '0;
            hi        <= '0;
            lo        <= '0;
            HiLoWrite <= '0;
        end else if (state == IDLE && Start) begin
            cnt    <= '0;
            is_div <= Op[1];
            sign_q <= !Op[0] && (A[WIDTH-1] ^ B[WIDTH-1]);
            sign_r <= !Op[0] && A[WIDTH-1];
            dbz    <= Op[1] && (B == '0);
            a_raw  <= A;
            mag_b  <= (!Op[0] && B[WIDTH-1]) ? -B : B;
            hi     <= '0;
            lo     <= mag_a;
        end else if (state == CALC) begin
            cnt <= cnt + CW'(1);
            hi  <= hi_n;
            lo  <= lo_n;
        end else if (state == FIXUP) begin
            HiLoWrite <= result;
        end
    end
    assign Stall     = (state == IDLE && Start) || state == CALC || state == FIXUP;
    assign Done      = state == WRITE;
    assign HiLoEn    = state == WRITE;
    assign DivByZero = state == WRITE && dbz;
endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb_hilo_muldiv_sequencer: directed vector table plus reset-abort and held-start sequences
module tb_hilo_muldiv_sequencer;
    localparam int W = 32;
    typedef struct {
        logic [1:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] hilo;
        logic           dbz;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [W-1:0] a = '0, b = '0;
    logic stall, busy, done, hilo_en, dbz;
    logic [2*W-1:0] hilo;
    int checks = 0, errors = 0;
    vec_t vecs[13];
    always #5 clk = ~clk;
    hilo_muldiv_sequencer #(.WIDTH(W)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .Op(op), .A(a), .B(b),
        .Stall(stall), .Busy(busy), .Done(done), .HiLoEn(hilo_en),
        .HiLoWrite(hilo), .DivByZero(dbz)
    );
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [2*W-1:0] exp_hl, input logic exp_dbz);
        int bad = 0;
        start = 1'b1; op = o; a = x; b = y;
        for (int c = 0; c <= W + 1; c++) begin
            #1;
            if (stall !== 1'b1 || hilo_en !== 1'b0 || done !== 1'b0 || dbz !== 1'b0 || busy !== (c != 0)) bad++;
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        check("busy_stall_seq", 64'(bad), 64'd0);
        check("write_flags", 64'({hilo_en, done, stall, busy}), 64'(4'b1100));
        check("hilo", hilo, exp_hl);
        check("dbz", 64'(dbz), 64'(exp_dbz));
        @(negedge clk);
        #1;
        check("idle_after", 64'({hilo_en, done, dbz, busy, stall}), 64'd0);
        check("hold", hilo, exp_hl);
    endtask
    initial begin
        int seen, n, first, second;
        logic stall34;
        vecs[0]  = '{2'b01, 32'd7,        32'd6,        64'h00000000_0000002A, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, 1'b0};
        vecs[2]  = '{2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0};
        vecs[4]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        64'h00000001_7FFFFFFC, 1'b0};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0};
        vecs[6]  = '{2'b11, 32'd100,      32'd0,        64'h00000064_FFFFFFFF, 1'b1};
        vecs[7]  = '{2'b10, 32'hFFFFFF9C, 32'd0,        64'hFFFFFF9C_FFFFFFFF, 1'b1};
        vecs[8]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0};
        vecs[9]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0};
        vecs[10] = '{2'b10, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0};
        vecs[11] = '{2'b11, 32'd5,        32'd7,        64'h00000005_00000000, 1'b0};
        vecs[12] = '{2'b01, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 1'b0};
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 64'({stall, busy, done, hilo_en, dbz}), 64'd0);
        check("reset_hilo", hilo, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 13; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hilo, vecs[i].dbz);
        // reset aborts an op in flight; a fresh op issued right after completes
        @(negedge clk);
        seen = 0;
        op = 2'b01;
        for (int c = 0; c <= 44; c++) begin
            start = (c == 0 || c == 11);
            rst = (c == 10);
            a = (c == 11) ? 32'd4 : 32'd3;
            b = (c == 11) ? 32'd5 : 32'd3;
            #1;
            if (c == 11) check("abort_idle", 64'({busy, stall}), 64'(2'b01));
            if (hilo_en) seen++;
            @(negedge clk);
        end
        start = 1'b0;
        #1;
        check("abort_no_write", 64'(seen), 64'd0);
        check("after_abort_en", 64'(hilo_en), 64'd1);
        check("after_abort_hilo", hilo, 64'd20);
        // Start held high: no retrigger in WRITE, back-to-back issue afterwards
        @(negedge clk);
        n = 0; first = -1; second = -1; stall34 = 1'bx;
        op = 2'b01; a = 32'd2; b = 32'd3;
        for (int c = 0; c <= 72; c++) begin
            start = (c <= 69);
            #1;
            if (hilo_en) begin
                n++;
                if (n == 1) first = c;
                else if (n == 2) second = c;
            end
            if (c == 34) stall34 = stall;
            @(negedge clk);
        end
        start = 1'b0;
        check("held_count", 64'(n), 64'd2);
        check("held_first", 64'(first), 64'd34);
        check("held_second", 64'(second), 64'd69);
        check("held_stall_write", 64'(stall34), 64'd0);
        check("held_hilo", hilo, 64'd6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
Multi-cycle multiply/divide engine and sequencer for the HiLo register.
- Accepts one MULT/MULTU/DIV/DIVU request from the decode/controller stage.
- Runs an iterative shift-add multiply or restoring divide over WIDTH cycles, on a single shared datapath.
- Stalls the PC while busy, then issues a one-cycle write to the HiLo register.

Parameters:
WIDTH, 32, operand width; HiLoWrite is 2*WIDTH bits; number of CALC iterations.

Ports:
Clk  input  1  system clock (the divided core clock in the top level)
Rst  input  1  synchronous reset, active-high
Start  input  1  request; sampled only in IDLE
Op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with Start
A  input  WIDTH  rs operand (multiplicand / dividend); sampled with Start
B  input  WIDTH  rt operand (multiplier / divisor); sampled with Start
Stall  output  1  combinational; hold PC and register-file writes
Busy  output  1  registered; high in CALC and FIXUP
Done  output  1  one-cycle pulse in WRITE
HiLoEn  output  1  HiLo write enable; high only in WRITE
HiLoWrite  output  2*WIDTH  {Hi,Lo} result
DivByZero  output  1  high in WRITE when a divide had B==0

Behaviour:
Reset:
- All sync to the Clk edge with Rst=1: state=IDLE, counter=0.
- Busy=0, Done=0, HiLoEn=0, DivByZero=0, HiLoWrite=0.
- Rst overrides everything, including mid-operation: the aborted operation never asserts HiLoEn.

States: IDLE, CALC, FIXUP, WRITE.

IDLE:
- Start=1 at an edge: latch Op and the operand magnitudes (abs for signed ops; raw for unsigned); record sign_q=A[msb]^B[msb] and sign_r=A[msb] for signed ops; clear accumulators; counter=0; go to CALC.

CALC:
- One iteration per edge; counter increments.
- The edge with counter==WIDTH-1 goes to FIXUP.
- CALC lasts exactly WIDTH cycles.
- Multiply: shift-add producing a 2*WIDTH magnitude product.
- Divide: restoring, one quotient bit per cycle, MSB first.

FIXUP (1 cycle):
- Apply signs; register the result into HiLoWrite; go to WRITE.
- MULT: negate the 2*WIDTH product if sign_q.
- DIV: negate the quotient if sign_q; negate the remainder if sign_r.
- All results wrap modulo 2^WIDTH, e.g. 0x80000000 / -1 gives Lo=0x80000000, Hi=0.
- B==0 on a divide (either op):
  - Hi=A as latched (original value, not magnitude).
  - Lo=all ones.
  - DivByZero set.
  - Latency unchanged.

WRITE (1 cycle):
- HiLoEn=1 and Done=1; DivByZero as computed.
- Unconditionally go to IDLE; HiLo captures at this edge.

Result mapping:
- Multiply: Hi = product[2W-1:W], Lo = product[W-1:0].
- Divide: Hi = remainder, Lo = quotient.

Stall:
- Stall = (IDLE & Start) | CALC | FIXUP.
- Stall is low in WRITE, so the PC advances at the same edge HiLo is written.

Timing:
- Start sampled at the end of cycle 0. CALC spans cycles 1..WIDTH, FIXUP is cycle WIDTH+1, WRITE is cycle WIDTH+2 (34 for WIDTH=32).
- Stall is high for cycles 0..WIDTH+1.

Start handling:
- Start is ignored outside IDLE; a held Start does not retrigger during WRITE.
- After WRITE, Start is accepted in the next IDLE cycle (back-to-back issue).

Output holding:
- HiLoWrite holds its last value outside WRITE; consumers qualify it with HiLoEn.
- Done, HiLoEn and DivByZero are 0 in all states except WRITE.

Test Plan:
- MULTU A=7, B=6, Start in cycle 0 -> Stall high cycles 0..33; cycle 34: HiLoEn=1, Done=1, HiLoWrite=0x00000000_0000002A; cycle 35: IDLE, HiLoEn=0.
- MULT A=0xFFFFFFFD (-3), B=5 -> HiLoWrite=0xFFFFFFFF_FFFFFFF1. MULT A=B=0x80000000 -> 0x40000000_00000000.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=0xFFFFFFF9, B=2 -> Lo=0x7FFFFFFC, Hi=1. DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=100, B=0 -> cycle 34: HiLoEn=1, DivByZero=1, Hi=0x00000064, Lo=0xFFFFFFFF; DivByZero=0 in cycle 35.
- Start MULTU 3*3, Rst=1 in cycle 10 -> cycle 11: IDLE, Busy=0, Stall=Start; HiLoEn never asserts for the aborted op; a new Start in cycle 11 completes with HiLoEn in cycle 45.
- Start held high continuously from cycle 0 with A=2, B=3, MULTU -> exactly one HiLoEn in cycle 34; second op accepted in cycle 35, HiLoEn again in cycle 69.
